// File: rtl/linedbl_mode_ctrl.sv
// linedbl_mode_ctrl
// Frame-synchronous configuration sequencer for the line-doubler datapath.
// It measures the incoming sync timing (lines per frame, PAL/NTSC, field ID,
// interlace) and declares lock after enough consistent frames. The requested
// doubler configuration is applied only at frame boundaries. Disruptive mode
// changes hold the doubler in reset and blank the output, so no torn frame
// reaches the DAC.
//
// Ports:
//   VCLK         pixel clock (2x sample rate)
//   RST          asynchronous active-high reset
//   sync_en      sync sample qualifier (every other VCLK)
//   nVS_i/nHS_i  active-low vertical / horizontal sync
//   cfg_i        requested config {nLinedbl, SL_in_osd, SLhyb_str, SL_str,
//                SL_method, SL_id, SL_en, x, x}
//   vinfo_dbl_o  applied config; bits [1:0] = {pal_det, interlaced_det}
//   dbl_rst_o    active-high reset to the doubler
//   blank_o      force black output
//   locked_o     timing lock indicator
//   line_cnt_o   lines counted in the last complete frame
module linedbl_mode_ctrl #(
  parameter int LOCK_FRAMES     = 3,
  parameter int BLANK_FRAMES    = 2,
  parameter int RST_CYCLES      = 16,
  parameter int PAL_LINE_THRESH = 288,
  parameter int MAX_LINES       = 700
) (
  input  logic        VCLK,
  input  logic        RST,
  input  logic        sync_en,
  input  logic        nVS_i,
  input  logic        nHS_i,
  input  logic [15:0] cfg_i,
  output logic [15:0] vinfo_dbl_o,
  output logic        dbl_rst_o,
  output logic        blank_o,
  output logic        locked_o,
  output logic [9:0]  line_cnt_o
);

  typedef enum logic [2:0] {UNLOCKED, LOCKING, RECONF, BLANK, RUN} state_e;

  localparam logic [9:0] PAL_THRESH = 10'(PAL_LINE_THRESH);
  localparam logic [9:0] MAX_L      = 10'(MAX_LINES);
  localparam logic [7:0] LOCK_N     = 8'(LOCK_FRAMES);
  localparam logic [7:0] BLANK_N    = 8'(BLANK_FRAMES);
  localparam logic [7:0] RST_LAST   = 8'(RST_CYCLES - 1);

  state_e      state_q, state_d;
  logic        nVsPrev_q, nHsPrev_q;
  logic [9:0]  hcnt_q, lineCnt_q;
  logic        fidLast_q;
  logic [7:0]  matchCnt_q, matchCnt_d;
  logic [7:0]  blankCnt_q, blankCnt_d;
  logic [7:0]  rstCnt_q, rstCnt_d;
  logic [15:0] vinfo_q, vinfo_d;
  logic        dblRst_q, dblRst_d;
  logic        blank_q, blank_d;
  logic        locked_q, locked_d;

  logic        vsNeg, hsNeg;
  logic [9:0]  hcntInc, lineDiff;
  logic        consistent, palNow, ilNow, overrun, disruptive, lossOfLock;
  logic        enterReconf;
  logic        unusedCfgBits;

  // The two lowest config bits are replaced by the detected timing flags.
  assign unusedCfgBits = ^cfg_i[1:0];

  // Falling edges exist only on qualified sample cycles.
  assign vsNeg = sync_en & nVsPrev_q & ~nVS_i;
  assign hsNeg = sync_en & nHsPrev_q & ~nHS_i;

  // An HS edge coinciding with VS is counted into the frame that is ending.
  assign hcntInc    = (hsNeg && hcnt_q != 10'h3FF) ? hcnt_q + 10'd1 : hcnt_q;
  assign lineDiff   = (hcntInc >= lineCnt_q) ? hcntInc - lineCnt_q : lineCnt_q - hcntInc;
  assign consistent = lineDiff <= 10'd1;
  assign palNow     = hcntInc >= PAL_THRESH;
  assign ilNow      = hsNeg != fidLast_q;
  assign overrun    = hcnt_q >= MAX_L;
  assign disruptive = (cfg_i[15] != vinfo_q[15]) || ({palNow, ilNow} != vinfo_q[1:0]);
  assign lossOfLock = (state_q != UNLOCKED) &&
                      (overrun || (vsNeg && !consistent && state_q != LOCKING));

  // Sync history and frame measurement run in every state.
  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      nVsPrev_q <= 1'b1;
      nHsPrev_q <= 1'b1;
      hcnt_q    <= '0;
      lineCnt_q <= '0;
      fidLast_q <= 1'b0;
    end else begin
      if (sync_en) begin
        nVsPrev_q <= nVS_i;
        nHsPrev_q <= nHS_i;
      end
      if (vsNeg) begin
        hcnt_q    <= '0;
        lineCnt_q <= hcntInc;
        fidLast_q <= hsNeg;
      end else begin
        hcnt_q <= hcntInc;
      end
    end
  end

  // State and sequencing counters.
  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      state_q    <= UNLOCKED;
      matchCnt_q <= '0;
      blankCnt_q <= '0;
      rstCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      matchCnt_q <= matchCnt_d;
      blankCnt_q <= blankCnt_d;
      rstCnt_q   <= rstCnt_d;
    end
  end

  // Next-state logic; loss of lock overrides whatever else was decided.
  always_comb begin
    state_d    = state_q;
    matchCnt_d = matchCnt_q;
    blankCnt_d = blankCnt_q;
    rstCnt_d   = rstCnt_q;
    case (state_q)
      UNLOCKED: begin
        if (vsNeg) begin
          state_d    = LOCKING;
          matchCnt_d = '0;
        end
      end
      LOCKING: begin
        if (vsNeg) begin
          if (!consistent) begin
            matchCnt_d = '0;
          end else if (matchCnt_q + 8'd1 >= LOCK_N) begin
            state_d  = RECONF;
            rstCnt_d = '0;
          end else begin
            matchCnt_d = matchCnt_q + 8'd1;
          end
        end
      end
      RECONF: begin
        if (rstCnt_q == RST_LAST) begin
          state_d    = BLANK;
          blankCnt_d = '0;
        end else begin
          rstCnt_d = rstCnt_q + 8'd1;
        end
      end
      BLANK: begin
        if (vsNeg) begin
          if (blankCnt_q + 8'd1 >= BLANK_N) begin
            state_d = RUN;
          end else begin
            blankCnt_d = blankCnt_q + 8'd1;
          end
        end
      end
      RUN: begin
        if (vsNeg && disruptive) begin
          state_d  = RECONF;
          rstCnt_d = '0;
        end
      end
      default: state_d = UNLOCKED;
    endcase
    if (lossOfLock) begin
      state_d = UNLOCKED;
    end
  end

  // Output decode from the next state, so every output is registered yet
  // changes in the same cycle as the state.
  always_comb begin
    enterReconf = (state_d == RECONF) && (state_q != RECONF);
    vinfo_d     = vinfo_q;
    if (lossOfLock) begin
      vinfo_d[15] = 1'b1;
    end else if (enterReconf) begin
      vinfo_d = {cfg_i[15:2], palNow, ilNow};
    end else if (state_q == RUN && vsNeg) begin
      vinfo_d[14:2] = cfg_i[14:2];
    end
    dblRst_d = (state_d == UNLOCKED) || (state_d == LOCKING) || (state_d == RECONF);
    blank_d  = (state_d == RECONF) || (state_d == BLANK);
    locked_d = (state_d == RECONF) || (state_d == BLANK) || (state_d == RUN);
  end

  // Output registers.
  always_ff @(posedge VCLK or posedge RST) begin
    if (RST) begin
      vinfo_q  <= 16'h8000;
      dblRst_q <= 1'b1;
      blank_q  <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      vinfo_q  <= vinfo_d;
      dblRst_q <= dblRst_d;
      blank_q  <= blank_d;
      locked_q <= locked_d;
    end
  end

  assign vinfo_dbl_o = vinfo_q;
  assign dbl_rst_o   = dblRst_q;
  assign blank_o     = blank_q;
  assign locked_o    = locked_q;
  assign line_cnt_o  = lineCnt_q;

endmodule

// File: tb/tb_linedbl_mode_ctrl.sv
// tb_linedbl_mode_ctrl
// Self-checking bench for linedbl_mode_ctrl. Drives synthetic sync streams
// (3 samples per line, VS on the last line of each frame) with randomized
// configuration words, and compares every output on every VCLK against a
// counter-based behavioural model of the sequencer.
module tb_linedbl_mode_ctrl;

  localparam int LOCK_FRAMES     = 3;
  localparam int BLANK_FRAMES    = 2;
  localparam int RST_CYCLES      = 16;
  localparam int PAL_LINE_THRESH = 288;
  localparam int MAX_LINES       = 700;

  logic        VCLK = 1'b0;
  logic        RST;
  logic        sync_en;
  logic        nVS_i;
  logic        nHS_i;
  logic [15:0] cfg_i;
  logic [15:0] vinfo_dbl_o;
  logic        dbl_rst_o;
  logic        blank_o;
  logic        locked_o;
  logic [9:0]  line_cnt_o;

  int compared   = 0;
  int mismatched = 0;
  int rstWin     = 0;
  int frameIdx   = 0;

  // Model state: lock is described by how many reset cycles and blank
  // frames remain, rather than by named states.
  bit          mPrevVs, mPrevHs, mLastFid, mTracking, mLocked;
  int          mHcnt, mLineCnt, mGood, mRstLeft, mBlankLeft;
  logic [15:0] eVinfo;

  always #5 VCLK = ~VCLK;

  linedbl_mode_ctrl #(
    .LOCK_FRAMES(LOCK_FRAMES), .BLANK_FRAMES(BLANK_FRAMES), .RST_CYCLES(RST_CYCLES),
    .PAL_LINE_THRESH(PAL_LINE_THRESH), .MAX_LINES(MAX_LINES)
  ) dut (
    .VCLK(VCLK), .RST(RST), .sync_en(sync_en), .nVS_i(nVS_i), .nHS_i(nHS_i),
    .cfg_i(cfg_i), .vinfo_dbl_o(vinfo_dbl_o), .dbl_rst_o(dbl_rst_o),
    .blank_o(blank_o), .locked_o(locked_o), .line_cnt_o(line_cnt_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPrevVs = 1'b1; mPrevHs = 1'b1; mLastFid = 1'b0;
    mTracking = 1'b0; mLocked = 1'b0;
    mHcnt = 0; mLineCnt = 0; mGood = 0; mRstLeft = 0; mBlankLeft = 0;
    eVinfo = 16'h8000;
  endtask

  task automatic startReconf(input bit pal, input bit il);
    eVinfo     = {cfg_i[15:2], pal, il};
    mLocked    = 1'b1;
    mRstLeft   = RST_CYCLES;
    mBlankLeft = 0;
  endtask

  // One VCLK of the reference behaviour, using the inputs present at the edge.
  task automatic modelStep();
    bit vsE, hsE, cons, pal, il, lost;
    int lines;
    vsE = sync_en && mPrevVs && !nVS_i;
    hsE = sync_en && mPrevHs && !nHS_i;
    if (sync_en) begin
      mPrevVs = nVS_i;
      mPrevHs = nHS_i;
    end
    lost  = (mTracking || mLocked) && (mHcnt >= MAX_LINES);
    lines = (hsE && mHcnt < 1023) ? mHcnt + 1 : mHcnt;
    cons = 1'b1; pal = 1'b0; il = 1'b0;
    if (vsE) begin
      pal  = lines >= PAL_LINE_THRESH;
      il   = hsE != mLastFid;
      cons = (lines - mLineCnt <= 1) && (mLineCnt - lines <= 1);
      mLastFid = hsE;
      mLineCnt = lines;
      mHcnt    = 0;
      if (mLocked && !cons) lost = 1'b1;
    end else begin
      mHcnt = lines;
    end
    if (lost) begin
      mTracking = 1'b0; mLocked = 1'b0; mRstLeft = 0; mBlankLeft = 0;
      eVinfo[15] = 1'b1;
    end else if (!mLocked) begin
      if (vsE) begin
        if (!mTracking) begin
          mTracking = 1'b1;
          mGood = 0;
        end else begin
          mGood = cons ? mGood + 1 : 0;
          if (mGood >= LOCK_FRAMES) startReconf(pal, il);
        end
      end
    end else if (mRstLeft > 0) begin
      mRstLeft--;
      if (mRstLeft == 0) mBlankLeft = BLANK_FRAMES;
    end else if (mBlankLeft > 0) begin
      if (vsE) mBlankLeft--;
    end else if (vsE) begin
      if (cfg_i[15] != eVinfo[15] || {pal, il} != eVinfo[1:0]) startReconf(pal, il);
      else eVinfo[14:2] = cfg_i[14:2];
    end
  endtask

  // Advance one VCLK and compare all outputs against the model.
  task automatic tick();
    @(posedge VCLK);
    #1;
    if (RST) modelReset();
    else modelStep();
    checkOutput("outputs",
                {3'b0, vinfo_dbl_o, dbl_rst_o, blank_o, locked_o, line_cnt_o},
                {3'b0, eVinfo, (!mLocked || mRstLeft > 0),
                 (mLocked && (mRstLeft > 0 || mBlankLeft > 0)), mLocked, 10'(mLineCnt)});
    if (locked_o && dbl_rst_o) rstWin++;
  endtask

  // One sync sample: a qualified VCLK followed by an unqualified one.
  task automatic applyStimulus(input logic nhs, input logic nvs);
    nHS_i = nhs;
    nVS_i = nvs;
    sync_en = 1'b1;
    tick();
    sync_en = 1'b0;
    tick();
  endtask

  // Frame of 'lines' lines; VS falls on the last line, together with HS when
  // fid is set. cfg_i switches to newCfg at line changeAt (if >= 0).
  task automatic sendFrame(input int lines, input bit fid, input logic [15:0] newCfg,
                           input int changeAt, input bit withVs);
    bit lastLine;
    for (int l = 0; l < lines; l++) begin
      lastLine = withVs && (l == lines - 1);
      if (l == changeAt) cfg_i = newCfg;
      applyStimulus(1'b0, !(lastLine && fid));
      applyStimulus(1'b1, !lastLine);
      applyStimulus(1'b1, !lastLine);
    end
  endtask

  task automatic sendPalFrame();
    if (frameIdx % 2 == 0) sendFrame(312, 1'b0, cfg_i, -1, 1'b1);
    else sendFrame(313, 1'b1, cfg_i, -1, 1'b1);
    frameIdx++;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_vinfo"}, vinfo_dbl_o, 16'h8000);
    checkOutput({tag, "_dblrst"}, dbl_rst_o, 1);
    checkOutput({tag, "_blank"}, blank_o, 0);
    checkOutput({tag, "_locked"}, locked_o, 0);
    checkOutput({tag, "_linecnt"}, line_cnt_o, 0);
  endtask

  initial begin
    logic [15:0] newCfg;
    RST = 1'b1; sync_en = 1'b0; nVS_i = 1'b1; nHS_i = 1'b1;
    cfg_i = 16'h0024 | 16'($urandom_range(0, 3));
    modelReset();
    repeat (3) tick();
    checkResetValues("reset");
    #2 RST = 1'b0;

    // NTSC 240p: lock at the 4th VS edge, 16-cycle doubler reset, 2 blank frames.
    rstWin = 0;
    for (int f = 1; f <= 6; f++) begin
      sendFrame(263, 1'b0, cfg_i, -1, 1'b1);
      if (f == 3) checkOutput("ntsc_unlocked_3rd", locked_o, 0);
      if (f == 4) checkOutput("ntsc_locked_4th", locked_o, 1);
      if (f == 5) checkOutput("ntsc_blank_frame2", blank_o, 1);
    end
    checkOutput("ntsc_run_blank", blank_o, 0);
    checkOutput("ntsc_rst_window", rstWin, RST_CYCLES);
    checkOutput("ntsc_vinfo", vinfo_dbl_o, 16'h0024);
    checkOutput("ntsc_linecnt", line_cnt_o, 263);

    // SL_str changed mid-frame, then random non-disruptive changes.
    newCfg = cfg_i;
    newCfg[8:5] = cfg_i[8:5] ^ 4'($urandom_range(1, 15));
    sendFrame(263, 1'b0, newCfg, $urandom_range(10, 250), 1'b1);
    checkOutput("sl_str_applied", vinfo_dbl_o[8:5], newCfg[8:5]);
    for (int f = 0; f < 3; f++) begin
      newCfg = {cfg_i[15], 13'($urandom), 2'($urandom)};
      sendFrame(263, 1'b0, newCfg, $urandom_range(1, 260), 1'b1);
      checkOutput("cfg_copy", vinfo_dbl_o[14:2], newCfg[14:2]);
    end
    checkOutput("no_rst_in_run", rstWin, RST_CYCLES);

    // Toggle nLinedbl: full reconfiguration.
    rstWin = 0;
    newCfg = cfg_i ^ 16'h8000;
    sendFrame(263, 1'b0, newCfg, $urandom_range(1, 260), 1'b1);
    checkOutput("toggle_blank", blank_o, 1);
    sendFrame(263, 1'b0, cfg_i, -1, 1'b1);
    sendFrame(263, 1'b0, cfg_i, -1, 1'b1);
    checkOutput("toggle_rst_window", rstWin, RST_CYCLES);
    checkOutput("toggle_bit15", vinfo_dbl_o[15], 1);
    checkOutput("toggle_run_blank", blank_o, 0);

    // VS removed: still locked at 699 lines, lost once 700 are counted.
    cfg_i[15] = 1'b0;
    sendFrame(263, 1'b0, cfg_i, -1, 1'b1);
    sendFrame(699, 1'b0, cfg_i, -1, 1'b0);
    checkOutput("novs_699_locked", locked_o, 1);
    sendFrame(6, 1'b0, cfg_i, -1, 1'b0);
    checkOutput("novs_locked", locked_o, 0);
    checkOutput("novs_bit15", vinfo_dbl_o[15], 1);
    checkOutput("novs_blank", blank_o, 0);

    // PAL 576i: alternating 312/313 lines and field ID.
    cfg_i = {1'b0, 15'($urandom)};
    frameIdx = 0;
    for (int f = 0; f < 8; f++) sendPalFrame();
    checkOutput("pal_flags", vinfo_dbl_o[1:0], 2'b11);
    checkOutput("pal_locked", locked_o, 1);
    checkOutput("pal_linecnt_313", line_cnt_o, 313);
    sendPalFrame();
    checkOutput("pal_linecnt_312", line_cnt_o, 312);

    // Disruptive change, then asynchronous reset in the middle of BLANK.
    cfg_i = cfg_i ^ 16'h8000;
    sendPalFrame();
    sendFrame(50, 1'b0, cfg_i, -1, 1'b0);
    checkOutput("blank_before_rst", blank_o, 1);
    #2 RST = 1'b1;
    #1 checkResetValues("async_rst");
    modelReset();
    repeat (3) tick();
    #2 RST = 1'b0;
    frameIdx = 0;
    for (int f = 1; f <= 7; f++) begin
      sendPalFrame();
      if (f == 3) checkOutput("relock_unlocked_3rd", locked_o, 0);
      if (f == 4) checkOutput("relock_locked_4th", locked_o, 1);
    end
    checkOutput("relock_vinfo", vinfo_dbl_o, {cfg_i[15:2], 2'b11});
    checkOutput("relock_blank", blank_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
